// File: rtl/rsa_limb_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rsa_limb_adapter                                              |
// | Purpose  : Width adapter between 32-bit word FIFOs and a K-bit-limb      |
// |            modular-exponentiation core. Packs N limbs from the forward   |
// |            FIFO, hands them to the core, then unpacks N result limbs     |
// |            into the backward FIFO and pulses done.                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rsa_limb_adapter #(
  parameter int K = 128,
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           rd_rdy,
  input  logic           rd_vld,
  input  logic [31:0]    rd_din,
  output logic           limb_vld,
  input  logic           limb_rdy,
  output logic [K-1:0]   limb_dat,
  output logic           limb_last,
  input  logic           res_vld,
  output logic           res_rdy,
  input  logic [K-1:0]   res_dat,
  output logic           wr_vld,
  input  logic           wr_rdy,
  output logic [31:0]    wr_dout
);

  localparam int WPL = K / 32;
  localparam int WW  = (WPL > 1) ? $clog2(WPL) : 1;
  localparam int LW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [WW-1:0] C_WLAST = WW'(WPL - 1);
  localparam logic [LW-1:0] C_LLAST = LW'(N - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_RECV  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [K-1:0]  sr_q, sr_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;

  // Next-state, shift-register and counter update; the shift register is
  // shared by both phases since operand and result traffic never overlap.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    wcnt_d  = wcnt_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
          lcnt_d  = '0;
        end
      end
      ST_LOAD: begin
        if (rd_vld) begin
          // Little-endian assembly: after WPL pops word 0 sits at bits [31:0].
          sr_d = {rd_din, sr_q[K-1:32]};
          if (wcnt_q == C_WLAST) begin
            wcnt_d  = '0;
            state_d = ST_SEND;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (limb_rdy) begin
          if (lcnt_q == C_LLAST) begin
            state_d = ST_RECV;
            wcnt_d  = '0;
            lcnt_d  = '0;
          end else begin
            lcnt_d  = lcnt_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_RECV: begin
        if (res_vld) begin
          sr_d    = res_dat;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wr_rdy) begin
          sr_d = {32'h0, sr_q[K-1:32]};
          if (wcnt_q == C_WLAST) begin
            wcnt_d = '0;
            if (lcnt_q == C_LLAST) begin
              state_d = ST_DONE;
            end else begin
              lcnt_d  = lcnt_q + 1'b1;
              state_d = ST_RECV;
            end
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, data and counter registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  // Handshake outputs depend on registers only, never on peer valid/ready.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rd_rdy    = (state_q == ST_LOAD);
  assign limb_vld  = (state_q == ST_SEND);
  assign limb_last = (state_q == ST_SEND) && (lcnt_q == C_LLAST);
  assign res_rdy   = (state_q == ST_RECV);
  assign wr_vld    = (state_q == ST_DRAIN);
  assign limb_dat  = sr_q;
  assign wr_dout   = sr_q[31:0];

endmodule
`default_nettype wire

// File: tb/tb_rsa_limb_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rsa_limb_adapter                                           |
// | Purpose  : Directed self-checking bench for rsa_limb_adapter with a FIFO |
// |            model, an echoing core model and a capture of pushed words.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rsa_limb_adapter;

  localparam int K = 128;
  localparam int N = 16;
  localparam int NW = N * K / 32;

  logic           clk = 1'b0;
  logic           rst, start, rd_vld, limb_rdy, res_vld, wr_rdy;
  logic [31:0]    rd_din;
  logic [K-1:0]   res_dat;
  logic           busy, done, rd_rdy, limb_vld, limb_last, res_rdy, wr_vld;
  logic [K-1:0]   limb_dat;
  logic [31:0]    wr_dout;

  // Second instance for the small-parameter sweep
  logic           s_rst, s_start, s_rd_vld, s_limb_rdy, s_res_vld, s_wr_rdy;
  logic [31:0]    s_rd_din;
  logic [63:0]    s_res_dat;
  logic           s_busy, s_done, s_rd_rdy, s_limb_vld, s_limb_last, s_res_rdy, s_wr_vld;
  logic [63:0]    s_limb_dat;
  logic [31:0]    s_wr_dout;

  always #5 clk = ~clk;

  rsa_limb_adapter #(.K(K), .N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_rdy(rd_rdy), .rd_vld(rd_vld), .rd_din(rd_din),
    .limb_vld(limb_vld), .limb_rdy(limb_rdy), .limb_dat(limb_dat), .limb_last(limb_last),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_dat(res_dat),
    .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_dout(wr_dout)
  );

  rsa_limb_adapter #(.K(64), .N(4)) dut_s (
    .clk(clk), .rst(s_rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_rdy(s_rd_rdy), .rd_vld(s_rd_vld), .rd_din(s_rd_din),
    .limb_vld(s_limb_vld), .limb_rdy(s_limb_rdy), .limb_dat(s_limb_dat), .limb_last(s_limb_last),
    .res_vld(s_res_vld), .res_rdy(s_res_rdy), .res_dat(s_res_dat),
    .wr_vld(s_wr_vld), .wr_rdy(s_wr_rdy), .wr_dout(s_wr_dout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Job bookkeeping
  logic [31:0]  fwd [0:NW-1];
  logic [31:0]  bwd [0:NW-1];
  logic [K-1:0] limbs [0:N-1];
  logic [K-1:0] echo_q [$];
  int rd_ptr, push_n, limb_n, done_n, done_cyc, last_n, last_idx, early_vld;

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < NW; i++) fwd[i] = base + 32'(i);
  endtask

  task automatic idle_inputs();
    start = 1'b0; rd_vld = 1'b0; rd_din = '0; limb_rdy = 1'b0;
    res_vld = 1'b0; res_dat = '0; wr_rdy = 1'b0;
  endtask

  // One job; rnd = 50% gaps on every peer, gap = FIFO holds 2 words until
  // cycle 22, poke = extra start pulses in LOAD/SEND/DRAIN, rst_mid = reset
  // during DRAIN of limb 7 (returns right after the post-reset check).
  task automatic run_job(input bit rnd, input bit gap, input bit poke, input bit rst_mid,
                         input int budget);
    int avail;
    bit p1, p2, p3, lstall, wstall, did_rst;
    logic [K-1:0] plimb;
    logic [31:0]  pword;
    rd_ptr = 0; push_n = 0; limb_n = 0; done_n = 0; done_cyc = -1;
    last_n = 0; last_idx = -1; early_vld = 0; echo_q.delete();
    p1 = 0; p2 = 0; p3 = 0; lstall = 0; wstall = 0; did_rst = 0;
    plimb = '0; pword = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c > 0 && done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (lstall) chk("limb_hold", limb_dat, plimb);
      if (wstall) chk("wr_hold", wr_dout, pword);
      if (gap && c < 22 && limb_vld) early_vld++;
      avail   = (gap && c < 22) ? 2 : NW;
      start   = (c == 0);
      if (poke && c > 1) begin
        if (rd_rdy && !p1) begin start = 1'b1; p1 = 1; end
        else if (limb_vld && !p2) begin start = 1'b1; p2 = 1; end
        else if (wr_vld && !p3) begin start = 1'b1; p3 = 1; end
      end
      rd_vld   = (rd_ptr < avail) && (!rnd || $urandom_range(0, 1) == 1);
      rd_din   = (rd_ptr < NW) ? fwd[rd_ptr] : 32'h0;
      limb_rdy = !rnd || $urandom_range(0, 1) == 1;
      res_vld  = (echo_q.size() > 0) && (!rnd || $urandom_range(0, 1) == 1);
      res_dat  = (echo_q.size() > 0) ? echo_q[0] : '0;
      wr_rdy   = !rnd || $urandom_range(0, 1) == 1;
      if (rst_mid && !did_rst && wr_vld && push_n == 29) begin
        rst = 1'b1; start = 1'b0; did_rst = 1;
      end
      if (did_rst) begin
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ctl", {busy, done, rd_rdy, limb_vld, limb_last, res_rdy, wr_vld}, 7'h0);
        chk("rst_mid_limb", limb_dat, '0);
        chk("rst_mid_wr", wr_dout, 32'h0);
        idle_inputs();
        return;
      end
      if (rd_rdy && rd_vld) rd_ptr++;
      lstall = limb_vld && !limb_rdy;
      plimb  = limb_dat;
      if (limb_vld && limb_rdy) begin
        if (limb_n < N) limbs[limb_n] = limb_dat;
        if (limb_last) begin last_n++; last_idx = limb_n; end
        echo_q.push_back(limb_dat);
        limb_n++;
      end
      if (res_vld && res_rdy) void'(echo_q.pop_front());
      wstall = wr_vld && !wr_rdy;
      pword  = wr_dout;
      if (wr_vld && wr_rdy) begin
        if (push_n < NW) bwd[push_n] = wr_dout;
        push_n++;
      end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    idle_inputs();
    if (done_cyc < 0) chk("done_timeout", 1'b1, 1'b0);
  endtask

  task automatic verify(input string tag, input int exp_cyc);
    chk({tag, "_done_n"}, done_n, 1);
    if (exp_cyc >= 0) chk({tag, "_done_cyc"}, done_cyc, exp_cyc);
    chk({tag, "_pops"}, rd_ptr, NW);
    chk({tag, "_pushes"}, push_n, NW);
    chk({tag, "_limb15"}, limbs[N-1], {fwd[63], fwd[62], fwd[61], fwd[60]});
    chk({tag, "_last_n"}, last_n, 1);
    chk({tag, "_last_idx"}, last_idx, N - 1);
    for (int i = 0; i < NW; i++) chk({tag, "_word"}, bwd[i], fwd[i]);
  endtask

  // Sweep instance bookkeeping
  logic [63:0] s_q [$];
  logic [31:0] s_bwd [0:7];
  logic [63:0] s_l0;
  int s_ptr, s_push, s_done_cyc, s_last_idx, s_last_n, s_limb_n;

  initial begin
    rst = 1'b1; s_rst = 1'b1;
    idle_inputs();
    s_start = 0; s_rd_vld = 0; s_rd_din = '0; s_limb_rdy = 0;
    s_res_vld = 0; s_res_dat = '0; s_wr_rdy = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {busy, done, rd_rdy, limb_vld, limb_last, res_rdy, wr_vld}, 7'h0);
    chk("reset_limb", limb_dat, '0);
    chk("reset_wr", wr_dout, 32'h0);
    rst = 1'b0; s_rst = 1'b0;
    @(negedge clk);

    // Basic job; first cycle after start must show busy/rd_rdy
    fill(32'h0);
    run_job(0, 0, 0, 0, 400);
    chk("basic_limb0", limbs[0], 128'h00000003_00000002_00000001_00000000);
    verify("basic", 161);

    // Random backpressure on all four interfaces
    fill(32'h0);
    run_job(1, 0, 0, 0, 3000);
    chk("bp_limb0", limbs[0], 128'h00000003_00000002_00000001_00000000);
    verify("bp", -1);

    // FIFO runs dry after two words
    fill(32'h1000_0000);
    run_job(0, 1, 0, 0, 600);
    chk("gap_no_send", early_vld, 0);
    chk("gap_limb0", limbs[0], 128'h10000003_10000002_10000001_10000000);
    verify("gap", -1);

    // start pulses while busy are ignored
    fill(32'h2000_0000);
    run_job(0, 0, 1, 0, 400);
    verify("poke", 161);

    // Reset during DRAIN of limb 7, then a fresh job
    fill(32'h3000_0000);
    run_job(0, 0, 0, 1, 400);
    fill(32'hA500_0000);
    run_job(0, 0, 0, 0, 400);
    chk("post_rst_limb0", limbs[0], 128'hA5000003_A5000002_A5000001_A5000000);
    verify("post_rst", 161);

    // K=64, N=4 instance, always-ready peers
    s_ptr = 0; s_push = 0; s_done_cyc = -1; s_last_idx = -1; s_last_n = 0;
    s_limb_n = 0; s_l0 = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c > 0 && s_done && s_done_cyc < 0) s_done_cyc = c;
      s_start    = (c == 0);
      s_rd_vld   = (s_ptr < 8);
      s_rd_din   = 32'(32'h10 + s_ptr);
      s_limb_rdy = 1'b1;
      s_res_vld  = (s_q.size() > 0);
      s_res_dat  = (s_q.size() > 0) ? s_q[0] : '0;
      s_wr_rdy   = 1'b1;
      if (s_rd_rdy && s_rd_vld) s_ptr++;
      if (s_limb_vld && s_limb_rdy) begin
        if (s_limb_n == 0) s_l0 = s_limb_dat;
        if (s_limb_last) begin s_last_n++; s_last_idx = s_limb_n; end
        s_q.push_back(s_limb_dat);
        s_limb_n++;
      end
      if (s_res_vld && s_res_rdy) void'(s_q.pop_front());
      if (s_wr_vld && s_wr_rdy) begin
        if (s_push < 8) s_bwd[s_push] = s_wr_dout;
        s_push++;
      end
      if (s_done_cyc >= 0 && c >= s_done_cyc + 2) break;
    end
    s_start = 0; s_rd_vld = 0; s_res_vld = 0;
    chk("sweep_done_cyc", s_done_cyc, 25);
    chk("sweep_limb0", s_l0, 64'h00000011_00000010);
    chk("sweep_last_n", s_last_n, 1);
    chk("sweep_last_idx", s_last_idx, 3);
    chk("sweep_pushes", s_push, 8);
    chk("sweep_w0", s_bwd[0], 32'h10);
    chk("sweep_w7", s_bwd[7], 32'h17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
